led_fade_driver: RTL

//  Output stage between the LED sequencer and the board pins. Takes a per-LED "lit" request vector.

---
 rtl/led_fade_driver_if.sv | 23 ++
 rtl/led_fade_driver.sv | 138 +++++++++++++
 2 files changed

// File: rtl/led_fade_driver_if.sv
// Pin-side bundle of the LED fade driver: request vector in, pin drive and timing pulses out.
interface led_fade_driver_if #(
    parameter int N_LEDS = 10
);
    logic [N_LEDS-1:0] led_req;
    logic [N_LEDS-1:0] led_out;
    logic              pwm_wrap;
    logic              decay_tick;

    modport master (
        output led_req,
        input  led_out,
        input  pwm_wrap,
        input  decay_tick
    );

    modport slave (
        input  led_req,
        output led_out,
        output pwm_wrap,
        output decay_tick
    );
endinterface

// File: rtl/led_fade_driver.sv
// PWM LED driver with exponential comet-trail decay and per-pin polarity.
// Optional build macro GAMMA_EN: squared-brightness compare with one extra pipeline stage.
module led_fade_driver #(
    parameter int               N_LEDS          = 10,
    parameter int               PWM_BITS        = 8,
    parameter int               DECAY_DIV       = 12000,
    parameter int               DECAY_SHIFT     = 3,
    parameter logic [N_LEDS-1:0] ACTIVE_LOW_MASK = 10'b1110000011
) (
    input  logic             CLK,
    input  logic             RST,
    led_fade_driver_if.slave bus
);
    localparam int                    DIV_W    = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(DECAY_DIV - 1);
    localparam logic [PWM_BITS-1:0]   MAX_V    = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0]   ZERO_V   = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0]   ONE_V    = PWM_BITS'(1);

    // Decay step is a fixed fraction of the current level, but never less than one LSB.
    function automatic logic [PWM_BITS-1:0] decay_next(input logic [PWM_BITS-1:0] b);
        logic [PWM_BITS-1:0] step;
        step = b >> DECAY_SHIFT;
        if (step == ZERO_V) begin
            step = ONE_V;
        end else begin
            step = step;
        end
        if (b == ZERO_V) begin
            return ZERO_V;
        end else begin
            return b - step;
        end
    endfunction

`ifdef GAMMA_EN
    function automatic logic [PWM_BITS-1:0] gamma_map(input logic [PWM_BITS-1:0] b);
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, b} * {{PWM_BITS{1'b0}}, b};
        if (b == MAX_V) begin
            return MAX_V;
        end else begin
            return PWM_BITS'(sq >> PWM_BITS);
        end
    endfunction
`endif

    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [DIV_W-1:0]    div_cnt_r;
    logic                pwm_wrap_r;
    logic                decay_tick_r;
    logic [N_LEDS-1:0]   led_out_r;
    logic [PWM_BITS-1:0] bright_r   [N_LEDS];
    logic [PWM_BITS-1:0] bright_nxt_s [N_LEDS];
    logic [PWM_BITS-1:0] cmp_s      [N_LEDS];
    logic [N_LEDS-1:0]   on_s;

    // Next brightness per LED: request beats the registered decay tick, which beats hold.
    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
            if (bus.led_req[i]) begin
                bright_nxt_s[i] = MAX_V;
            end else if (decay_tick_r) begin
                bright_nxt_s[i] = decay_next(bright_r[i]);
            end else begin
                bright_nxt_s[i] = bright_r[i];
            end
        end
    end

`ifdef GAMMA_EN
    logic [PWM_BITS-1:0] gamma_r [N_LEDS];

    // Gamma-corrected compare level, registered to keep the multiplier off the compare path.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < N_LEDS; i++) begin
            if (RST) begin
                gamma_r[i] <= ZERO_V;
            end else begin
                gamma_r[i] <= gamma_map(bright_r[i]);
            end
        end
    end

    // Compare level taken from the gamma stage.
    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
            cmp_s[i] = gamma_r[i];
        end
    end
`else
    // Compare level is the raw brightness.
    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
            cmp_s[i] = bright_r[i];
        end
    end
`endif

    // Duty compare; a full-scale level stays lit through the MAX slot of the PWM period.
    always_comb begin
        on_s = {N_LEDS{1'b0}};
        for (int i = 0; i < N_LEDS; i++) begin
            on_s[i] = (cmp_s[i] == MAX_V) | (cmp_s[i] > pwm_cnt_r);
        end
    end

    // Counters, pulses, brightness state and polarity-corrected pin drive.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pwm_cnt_r    <= ZERO_V;
            div_cnt_r    <= {DIV_W{1'b0}};
            pwm_wrap_r   <= 1'b0;
            decay_tick_r <= 1'b0;
            led_out_r    <= ACTIVE_LOW_MASK;
            for (int i = 0; i < N_LEDS; i++) begin
                bright_r[i] <= ZERO_V;
            end
        end else begin
            pwm_cnt_r    <= pwm_cnt_r + ONE_V;
            pwm_wrap_r   <= (pwm_cnt_r == MAX_V);
            decay_tick_r <= (div_cnt_r == DIV_LAST);
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r <= {DIV_W{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
            led_out_r <= on_s ^ ACTIVE_LOW_MASK;
            for (int i = 0; i < N_LEDS; i++) begin
                bright_r[i] <= bright_nxt_s[i];
            end
        end
    end

    assign bus.led_out    = led_out_r;
    assign bus.pwm_wrap   = pwm_wrap_r;
    assign bus.decay_tick = decay_tick_r;
endmodule
